// File: rtl/vga_text_pkg.sv
// Shared text-console definitions: default screen size, derived character-grid
// limits, controller state encoding and the control bytes the console interprets.
package vga_text_pkg;

    localparam int H_DISP_DEF = 1280;
    localparam int V_DISP_DEF = 1024;

    function automatic int calc_x_limit(input int h_disp);
        return h_disp / 8;
    endfunction

    function automatic int calc_y_limit(input int v_disp);
        return v_disp / 8;
    endfunction

    function automatic int calc_addr_limit(input int h_disp, input int v_disp);
        return (h_disp / 8) * (v_disp / 8);
    endfunction

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SCROLL = 2'd1,
        ST_CLEAR  = 2'd2,
        ST_INIT   = 2'd3
    } state_t;

    localparam logic [7:0] CH_BS    = 8'h08;
    localparam logic [7:0] CH_LF    = 8'h0A;
    localparam logic [7:0] CH_CR    = 8'h0D;
    localparam logic [7:0] CH_SP    = 8'h20;
    localparam logic [7:0] CH_TILDE = 8'h7E;

endpackage

// File: rtl/vga_console.sv
// Character-stream text console: turns a byte stream into text-buffer writes with a
// scrolling ring buffer. Macro VGA_CONSOLE_INIT_CLEAR_EN adds a full-screen clear after reset.
module vga_console
    import vga_text_pkg::*;
#(
    parameter int  h_disp     = H_DISP_DEF,
    parameter int  v_disp     = V_DISP_DEF,
    localparam int x_limit    = calc_x_limit(h_disp),
    localparam int y_limit    = calc_y_limit(v_disp),
    localparam int addr_limit = calc_addr_limit(h_disp, v_disp),
    localparam int addr_width = $clog2(addr_limit)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [7:0]            char_in,
    input  logic                  char_valid,
    output logic                  char_ready,
    output logic [addr_width-1:0] addr_init,
    output logic [addr_width-1:0] addr_write,
    output logic                  write_enable,
    output logic [7:0]            char_write,
    output logic [7:0]            cursor_x,
    output logic [7:0]            cursor_y
);

    localparam logic [addr_width-1:0] ROW_STEP  = addr_width'(x_limit);
    localparam logic [addr_width-1:0] LAST_ROW  = addr_width'((y_limit - 1) * x_limit);
    localparam logic [addr_width-1:0] WRAP_AT   = addr_width'(addr_limit - x_limit);
    localparam logic [addr_width-1:0] CLR_ROW_E = addr_width'(x_limit - 1);
    localparam logic [addr_width-1:0] CLR_ALL_E = addr_width'(addr_limit - 1);
    localparam logic [addr_width-1:0] ONE       = addr_width'(1);
    localparam logic [7:0]            X_MAX     = 8'(x_limit - 1);
    localparam logic [7:0]            Y_MAX     = 8'(y_limit - 1);

`ifdef VGA_CONSOLE_INIT_CLEAR_EN
    localparam state_t RST_STATE = ST_INIT;
`else
    localparam state_t RST_STATE = ST_IDLE;
`endif

    state_t                state, state_nx;
    logic [addr_width-1:0] clr_cnt;
    logic [addr_width-1:0] cur_addr, wr_addr;
    logic [7:0]            nx_x, nx_y, wr_byte;
    logic                  accept, do_wr, row_adv, scroll;

    assign accept   = char_valid && char_ready;
    assign cur_addr = addr_width'(cursor_y) * ROW_STEP + addr_width'(cursor_x);
    assign scroll   = row_adv && (cursor_y == Y_MAX);

    // Character decode: what the accepted byte does to the cursor and the buffer.
    always_comb begin
        do_wr   = 1'b0;
        wr_byte = CH_SP;
        wr_addr = cur_addr;
        nx_x    = cursor_x;
        nx_y    = cursor_y;
        row_adv = 1'b0;
        if (char_in >= CH_SP && char_in <= CH_TILDE) begin
            do_wr   = 1'b1;
            wr_byte = char_in;
            if (cursor_x == X_MAX) begin
                nx_x    = 8'd0;
                row_adv = 1'b1;
            end else begin
                nx_x = cursor_x + 8'd1;
            end
        end else if (char_in == CH_LF) begin
            nx_x    = 8'd0;
            row_adv = 1'b1;
        end else if (char_in == CH_CR) begin
            nx_x = 8'd0;
        end else if (char_in == CH_BS && cursor_x != 8'd0) begin
            nx_x    = cursor_x - 8'd1;
            do_wr   = 1'b1;
            wr_addr = cur_addr - ONE;
        end
        // The bottom row stays put; the scroll moves the buffer instead.
        if (row_adv && cursor_y != Y_MAX)
            nx_y = cursor_y + 8'd1;
    end

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE:   if (accept && scroll) state_nx = ST_SCROLL;
            ST_SCROLL: state_nx = ST_CLEAR;
            ST_CLEAR:  if (clr_cnt == CLR_ROW_E) state_nx = ST_IDLE;
            ST_INIT:   if (clr_cnt == CLR_ALL_E) state_nx = ST_IDLE;
            default:   state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= RST_STATE;
            char_ready   <= 1'b0;
            addr_init    <= '0;
            addr_write   <= '0;
            write_enable <= 1'b0;
            char_write   <= 8'h00;
            cursor_x     <= 8'd0;
            cursor_y     <= 8'd0;
            clr_cnt      <= '0;
        end else begin
            state        <= state_nx;
            char_ready   <= (state_nx == ST_IDLE);
            write_enable <= 1'b0;
            case (state)
                ST_IDLE: if (accept) begin
                    cursor_x <= nx_x;
                    cursor_y <= nx_y;
                    if (do_wr) begin
                        write_enable <= 1'b1;
                        addr_write   <= wr_addr;
                        char_write   <= wr_byte;
                    end
                end
                ST_SCROLL: begin
                    // Base addresses are row multiples, so reaching WRAP_AT means wrap to 0.
                    addr_init <= (addr_init >= WRAP_AT) ? addr_init - WRAP_AT
                                                        : addr_init + ROW_STEP;
                    clr_cnt   <= '0;
                end
                ST_CLEAR, ST_INIT: begin
                    write_enable <= 1'b1;
                    addr_write   <= ((state == ST_CLEAR) ? LAST_ROW : '0) + clr_cnt;
                    char_write   <= CH_SP;
                    clr_cnt      <= clr_cnt + ONE;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_vga_console.sv
// Directed bench for vga_console at the default 1280x1024 geometry (160x128 cells).
module tb_vga_console;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  char_in = 8'h00;
    logic        char_valid = 1'b0;
    logic        char_ready;
    logic [14:0] addr_init;
    logic [14:0] addr_write;
    logic        write_enable;
    logic [7:0]  char_write;
    logic [7:0]  cursor_x;
    logic [7:0]  cursor_y;

    int vecs = 0;
    int errs = 0;

    vga_console dut (
        .clk(clk), .rst_n(rst_n), .char_in(char_in), .char_valid(char_valid),
        .char_ready(char_ready), .addr_init(addr_init), .addr_write(addr_write),
        .write_enable(write_enable), .char_write(char_write),
        .cursor_x(cursor_x), .cursor_y(cursor_y)
    );

    always #5 clk = ~clk;

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        char_valid = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    // Returns at the negedge after the accept edge, with that cycle's write outputs.
    task automatic send(input logic [7:0] c, output logic wr, output logic [14:0] a,
                        output logic [7:0] d);
        int n;
        n = 0;
        @(negedge clk);
        while (!char_ready && n < 1000) begin
            @(negedge clk);
            n++;
        end
        if (!char_ready) begin
            vecs++; errs++;
            $display("FAIL send_ready_timeout: char_ready=%0b required 1", char_ready);
        end
        char_in = c;
        char_valid = 1'b1;
        @(negedge clk);
        char_valid = 1'b0;
        wr = write_enable;
        a = addr_write;
        d = char_write;
    endtask

    task automatic wait_ready(input string tag);
        int n;
        n = 0;
        while (!char_ready && n < 1000) begin
            @(negedge clk);
            n++;
        end
        vecs++;
        if (char_ready !== 1'b1) begin
            errs++;
            $display("FAIL %s_ready_timeout: char_ready=%0b required 1", tag, char_ready);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        vecs++;
        if ({char_ready, write_enable, addr_init, addr_write, char_write, cursor_x, cursor_y}
            !== '0) begin
            errs++;
            $display("FAIL reset_outputs: rdy=%0b we=%0b init=%0d aw=%0d cw=%h x=%0d y=%0d required all 0",
                     char_ready, write_enable, addr_init, addr_write, char_write, cursor_x, cursor_y);
        end
        rst_n = 1'b1;
        #1;
        vecs++;
        if (char_ready !== 1'b0) begin
            errs++;
            $display("FAIL reset_release_ready: got %0b required 0 before first edge", char_ready);
        end
        @(negedge clk);
        vecs++;
        if (char_ready !== 1'b1 || write_enable !== 1'b0) begin
            errs++;
            $display("FAIL reset_first_edge: rdy=%0b we=%0b required 1/0", char_ready, write_enable);
        end
    endtask

    task automatic test_print();
        logic wr; logic [14:0] a; logic [7:0] d;
        do_reset();
        send(8'h41, wr, a, d);
        vecs++;
        if (wr !== 1'b1 || a !== 15'd0 || d !== 8'h41) begin
            errs++;
            $display("FAIL print_write: we=%0b addr=%0d data=%h required 1/0/41", wr, a, d);
        end
        vecs++;
        if (cursor_x !== 8'd1 || cursor_y !== 8'd0 || addr_init !== 15'd0) begin
            errs++;
            $display("FAIL print_cursor: x=%0d y=%0d init=%0d required 1/0/0", cursor_x, cursor_y, addr_init);
        end
        @(negedge clk);
        vecs++;
        if (write_enable !== 1'b0) begin
            errs++;
            $display("FAIL print_single_strobe: we=%0b required 0", write_enable);
        end
    endtask

    task automatic test_row_fill();
        logic wr; logic [14:0] a; logic [7:0] d;
        int bad;
        bad = 0;
        do_reset();
        for (int i = 0; i < 160; i++) begin
            send(8'h42, wr, a, d);
            if (wr !== 1'b1 || a !== 15'(i) || d !== 8'h42) bad++;
        end
        vecs++;
        if (bad != 0 || a !== 15'd159) begin
            errs++;
            $display("FAIL row_fill_writes: bad=%0d last_addr=%0d required 0/159", bad, a);
        end
        vecs++;
        if (cursor_x !== 8'd0 || cursor_y !== 8'd1 || addr_init !== 15'd0 || char_ready !== 1'b1) begin
            errs++;
            $display("FAIL row_fill_cursor: x=%0d y=%0d init=%0d rdy=%0b required 0/1/0/1",
                     cursor_x, cursor_y, addr_init, char_ready);
        end
    endtask

    task automatic test_ignore();
        logic wr; logic [14:0] a; logic [7:0] d;
        // Starts at (0,1) from the row fill; print two then feed junk bytes.
        send(8'h43, wr, a, d);
        send(8'h43, wr, a, d);
        send(8'h01, wr, a, d);
        vecs++;
        if (wr !== 1'b0 || cursor_x !== 8'd2 || cursor_y !== 8'd1) begin
            errs++;
            $display("FAIL ignore_01: we=%0b x=%0d y=%0d required 0/2/1", wr, cursor_x, cursor_y);
        end
        send(8'h7F, wr, a, d);
        vecs++;
        if (wr !== 1'b0 || cursor_x !== 8'd2) begin
            errs++;
            $display("FAIL ignore_7f: we=%0b x=%0d required 0/2", wr, cursor_x);
        end
        send(8'h0D, wr, a, d);
        vecs++;
        if (wr !== 1'b0 || cursor_x !== 8'd0 || cursor_y !== 8'd1) begin
            errs++;
            $display("FAIL cr: we=%0b x=%0d y=%0d required 0/0/1", wr, cursor_x, cursor_y);
        end
    endtask

    task automatic test_backspace();
        logic wr; logic [14:0] a; logic [7:0] d;
        do_reset();
        send(8'h0A, wr, a, d);
        vecs++;
        if (wr !== 1'b0 || cursor_y !== 8'd1) begin
            errs++;
            $display("FAIL lf_nowrite: we=%0b y=%0d required 0/1", wr, cursor_y);
        end
        send(8'h0A, wr, a, d);
        for (int i = 0; i < 5; i++) send(8'h61, wr, a, d);
        send(8'h08, wr, a, d);
        vecs++;
        if (wr !== 1'b1 || a !== 15'd324 || d !== 8'h20) begin
            errs++;
            $display("FAIL bs_write: we=%0b addr=%0d data=%h required 1/324/20", wr, a, d);
        end
        vecs++;
        if (cursor_x !== 8'd4 || cursor_y !== 8'd2) begin
            errs++;
            $display("FAIL bs_cursor: x=%0d y=%0d required 4/2", cursor_x, cursor_y);
        end
        send(8'h0D, wr, a, d);
        send(8'h08, wr, a, d);
        vecs++;
        if (wr !== 1'b0 || cursor_x !== 8'd0 || cursor_y !== 8'd2) begin
            errs++;
            $display("FAIL bs_at_col0: we=%0b x=%0d y=%0d required 0/0/2", wr, cursor_x, cursor_y);
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        char_in = 8'h48; char_valid = 1'b1;
        @(negedge clk);
        vecs++;
        if (write_enable !== 1'b1 || addr_write !== 15'd0 || char_write !== 8'h48 || char_ready !== 1'b1) begin
            errs++;
            $display("FAIL b2b_first: we=%0b addr=%0d data=%h rdy=%0b required 1/0/48/1",
                     write_enable, addr_write, char_write, char_ready);
        end
        char_in = 8'h49;
        @(negedge clk);
        char_valid = 1'b0;
        vecs++;
        if (write_enable !== 1'b1 || addr_write !== 15'd1 || char_write !== 8'h49) begin
            errs++;
            $display("FAIL b2b_second: we=%0b addr=%0d data=%h required 1/1/49",
                     write_enable, addr_write, char_write);
        end
        @(negedge clk);
        vecs++;
        if (write_enable !== 1'b0 || cursor_x !== 8'd2) begin
            errs++;
            $display("FAIL b2b_idle: we=%0b x=%0d required 0/2", write_enable, cursor_x);
        end
    endtask

    task automatic test_scroll();
        logic wr; logic [14:0] a; logic [7:0] d;
        int low, nwr, bad;
        logic [14:0] first_a, last_a;
        do_reset();
        for (int i = 0; i < 127; i++) send(8'h0A, wr, a, d);
        vecs++;
        if (cursor_y !== 8'd127 || addr_init !== 15'd0) begin
            errs++;
            $display("FAIL scroll_setup: y=%0d init=%0d required 127/0", cursor_y, addr_init);
        end
        for (int i = 0; i < 3; i++) send(8'h63, wr, a, d);
        send(8'h0A, wr, a, d);
        vecs++;
        if (addr_init !== 15'd0 || char_ready !== 1'b0) begin
            errs++;
            $display("FAIL scroll_cycle: init=%0d rdy=%0b required 0/0", addr_init, char_ready);
        end
        low = 0; nwr = 0; bad = 0; first_a = '0; last_a = '0;
        for (int i = 0; i < 170; i++) begin
            if (!char_ready) low++;
            if (write_enable) begin
                if (nwr == 0) first_a = addr_write;
                if (addr_write !== 15'(20320 + nwr) || char_write !== 8'h20) bad++;
                last_a = addr_write;
                nwr++;
            end
            @(negedge clk);
        end
        vecs++;
        if (low != 161) begin
            errs++;
            $display("FAIL scroll_ready_low: %0d cycles required 161", low);
        end
        vecs++;
        if (nwr != 160 || bad != 0 || first_a !== 15'd20320 || last_a !== 15'd20479) begin
            errs++;
            $display("FAIL scroll_clear: n=%0d bad=%0d first=%0d last=%0d required 160/0/20320/20479",
                     nwr, bad, first_a, last_a);
        end
        vecs++;
        if (addr_init !== 15'd160 || cursor_x !== 8'd0 || cursor_y !== 8'd127) begin
            errs++;
            $display("FAIL scroll_state: init=%0d x=%0d y=%0d required 160/0/127",
                     addr_init, cursor_x, cursor_y);
        end
    endtask

    task automatic test_scroll_wrap();
        logic wr; logic [14:0] a; logic [7:0] d;
        // One scroll already done; 126 more by LF, the 128th by a printable at x=159.
        for (int i = 0; i < 126; i++) send(8'h0A, wr, a, d);
        wait_ready("wrap_lf");
        vecs++;
        if (addr_init !== 15'd20320) begin
            errs++;
            $display("FAIL wrap_pre: init=%0d required 20320", addr_init);
        end
        for (int i = 0; i < 159; i++) send(8'h63, wr, a, d);
        send(8'h5A, wr, a, d);
        vecs++;
        if (wr !== 1'b1 || a !== 15'd20479 || d !== 8'h5A || addr_init !== 15'd20320) begin
            errs++;
            $display("FAIL wrap_scroll_write: we=%0b addr=%0d data=%h init=%0d required 1/20479/5a/20320",
                     wr, a, d, addr_init);
        end
        wait_ready("wrap_last");
        vecs++;
        if (addr_init !== 15'd0 || cursor_x !== 8'd0 || cursor_y !== 8'd127) begin
            errs++;
            $display("FAIL wrap_result: init=%0d x=%0d y=%0d required 0/0/127",
                     addr_init, cursor_x, cursor_y);
        end
    endtask

    task automatic test_reset_mid_clear();
        logic wr; logic [14:0] a; logic [7:0] d;
        send(8'h0A, wr, a, d);
        repeat (50) @(negedge clk);
        vecs++;
        if (write_enable !== 1'b1) begin
            errs++;
            $display("FAIL midclear_active: we=%0b required 1", write_enable);
        end
        #2 rst_n = 1'b0;
        #1;
        vecs++;
        if ({char_ready, write_enable, addr_init, addr_write, char_write, cursor_x, cursor_y}
            !== '0) begin
            errs++;
            $display("FAIL midclear_async: rdy=%0b we=%0b init=%0d aw=%0d cw=%h x=%0d y=%0d required all 0",
                     char_ready, write_enable, addr_init, addr_write, char_write, cursor_x, cursor_y);
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        vecs++;
        if (char_ready !== 1'b1 || write_enable !== 1'b0 || addr_init !== 15'd0 ||
            addr_write !== 15'd0 || char_write !== 8'h00 || cursor_x !== 8'd0 || cursor_y !== 8'd0) begin
            errs++;
            $display("FAIL midclear_release: rdy=%0b we=%0b init=%0d aw=%0d cw=%h x=%0d y=%0d required 1/0/0/0/00/0/0",
                     char_ready, write_enable, addr_init, addr_write, char_write, cursor_x, cursor_y);
        end
        repeat (5) @(negedge clk);
        vecs++;
        if (write_enable !== 1'b0) begin
            errs++;
            $display("FAIL midclear_no_resume: we=%0b required 0", write_enable);
        end
    endtask

    initial begin
        test_reset();
        test_print();
        test_row_fill();
        test_ignore();
        test_backspace();
        test_back_to_back();
        test_scroll();
        test_scroll_wrap();
        test_reset_mid_clear();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
